// File: rtl/mips_write_buffer.sv
// mips_write_buffer: posted-write buffer between a MIPS core and an Avalon-MM master port.
// Latency: a write enqueued on edge N is driven on the bus from edge N+1; a zero-wait read stalls the core 2 cycles.
// Backpressure: cpu_stall holds the core while the buffer is full or while a read is outstanding.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   cpu_*                core request (address/byteenable/writedata/read/write), cpu_readdata, cpu_stall
//   address..write       registered Avalon master outputs; waitrequest/readdata from the slave
//   wb_empty             no write buffered and none in flight on the bus
module mips_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        wb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Posted-write storage; contents need no reset, only the pointers do.
  logic [31:0]   fifo_addr [DEPTH];
  logic [3:0]    fifo_be   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic        full, enq, pop, rd_done;
  logic [31:0] address_nxt, writedata_nxt;
  logic [3:0]  byteenable_nxt;
  logic        read_nxt, write_nxt;

  assign full = (count == CW'(DEPTH));

  // A simultaneous read+write request is serviced as a read; the write half is dropped.
  assign enq = cpu_write & ~cpu_read & ~full;

  // A read stalls until the single RDONE cycle, where cpu_readdata is already valid.
  assign cpu_stall = reset
                   | (cpu_read & (state != RDONE))
                   | (cpu_write & ~cpu_read & full);

  assign wb_empty = (count == '0) & (state != WRITE);

  // Bus FSM: next state and next values of the registered master outputs.
  always_comb begin
    state_nxt      = state;
    address_nxt    = address;
    byteenable_nxt = byteenable;
    writedata_nxt  = writedata;
    read_nxt       = read;
    write_nxt      = write;
    pop            = 1'b0;
    rd_done        = 1'b0;
    case (state)
      IDLE: begin
        // Buffered writes go first so a read never overtakes an older write.
        if (count != '0) begin
          state_nxt      = WRITE;
          address_nxt    = fifo_addr[head];
          byteenable_nxt = fifo_be[head];
          writedata_nxt  = fifo_data[head];
          write_nxt      = 1'b1;
        end else if (cpu_read) begin
          state_nxt      = READ;
          address_nxt    = cpu_address;
          byteenable_nxt = cpu_byteenable;
          read_nxt       = 1'b1;
        end
      end
      WRITE: begin
        // Head stays in the FIFO until the slave accepts it.
        if (!waitrequest) begin
          pop       = 1'b1;
          write_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (!waitrequest) begin
          rd_done   = 1'b1;
          read_nxt  = 1'b0;
          state_nxt = RDONE;
        end
      end
      RDONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      address      <= '0;
      byteenable   <= '0;
      writedata    <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      cpu_readdata <= '0;
    end else begin
      state      <= state_nxt;
      address    <= address_nxt;
      byteenable <= byteenable_nxt;
      writedata  <= writedata_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      if (rd_done) begin
        cpu_readdata <= readdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[tail] <= cpu_address;
      fifo_be[tail]   <= cpu_byteenable;
      fifo_data[tail] <= cpu_writedata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_write_buffer.sv
// Bench for mips_write_buffer: cycle table, hand-written corner sequences and
// randomized traffic against a memory-level reference model.
module tb_mips_write_buffer;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_address;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_writedata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        wb_empty;

  // Slave side: either the table drives it, or the automatic slave model does.
  logic        slave_auto;
  int          slave_mode;  // 0 always ready, 1 always waiting, 2 random
  logic        tb_wait, sl_wait;
  logic [31:0] tb_rdata, sl_rdata;

  assign waitrequest = slave_auto ? sl_wait : tb_wait;
  assign readdata    = slave_auto ? sl_rdata : tb_rdata;

  mips_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable),
    .cpu_writedata(cpu_writedata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .read(read), .write(write),
    .waitrequest(waitrequest), .readdata(readdata), .wb_empty(wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t         bus_q[$];   // writes the slave accepted, in bus order
  wr_t         exp_q[$];   // writes the core posted, in program order
  int          bus_base;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (slave_mode == 0)      sl_wait = 1'b0;
    else if (slave_mode == 1) sl_wait = 1'b1;
    else                      sl_wait = ($urandom_range(0, 1) == 1);
    sl_rdata = slave_mem.exists(address) ? slave_mem[address] : 32'h0;
  end

  always @(posedge clk) begin
    if (!reset && write && !waitrequest) begin
      bus_q.push_back('{address, byteenable, writedata});
      slave_mem[address] = merge(slave_mem.exists(address) ? slave_mem[address] : 32'h0,
                                 writedata, byteenable);
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge and check per-cycle invariants.
  task automatic tick();
    @(negedge clk);
    #1;
    if (!reset) begin
      chk1("rw_exclusive", read & write, 1'b0);
      if (read) chk1("read_after_writes", wb_empty, 1'b1);
    end
  endtask

  task automatic idle_inputs();
    cpu_address = '0; cpu_byteenable = '0; cpu_writedata = '0;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit acc;
    acc = 0;
    cpu_address = a; cpu_byteenable = be; cpu_writedata = d;
    cpu_read = 1'b0; cpu_write = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      #1;
      if (!cpu_stall) begin
        acc = 1;
        exp_q.push_back('{a, be, d});
        ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, be);
      end
      tick();
    end
    cpu_write = 1'b0;
    if (!acc) chk1("write_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic cpu_rd(input logic [31:0] a, input int exp_stalls);
    bit          done;
    int          stalls;
    logic [31:0] e;
    done = 0; stalls = 0;
    e = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    cpu_address = a; cpu_byteenable = 4'hF; cpu_writedata = '0;
    cpu_write = 1'b0; cpu_read = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (!cpu_stall) begin
        done = 1;
        chk32("read_data", cpu_readdata, e);
      end else begin
        stalls++;
      end
      tick();
    end
    cpu_read = 1'b0;
    if (!done) chk1("read_timeout", 1'b0, 1'b1);
    else if (exp_stalls >= 0) chk32("read_stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic drain_and_compare();
    int n;
    for (int i = 0; i < 500 && !wb_empty; i++) tick();
    chk1("drain_empty", wb_empty, 1'b1);
    n = bus_q.size() - bus_base;
    chk32("bus_write_count", 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk32("bus_addr",  bus_q[bus_base + i].a, exp_q[i].a);
      chk32("bus_be",    {28'h0, bus_q[bus_base + i].be}, {28'h0, exp_q[i].be});
      chk32("bus_wdata", bus_q[bus_base + i].d, exp_q[i].d);
    end
    bus_base = bus_q.size();
    exp_q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus_base = bus_q.size();
    exp_q.delete();
  endtask

  // Cycle table: inputs for one cycle and the outputs expected during that cycle.
  typedef struct {
    logic        wr, rd;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wt;
    logic [31:0] rdat;
    logic        e_write, e_read, e_stall, e_empty;
    logic [31:0] e_addr, e_wdat, e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic wr, logic rd, logic [31:0] a, logic [3:0] be,
                              logic [31:0] wd, logic wt, logic [31:0] rdat,
                              logic ew, logic er, logic es, logic ee,
                              logic [31:0] ea, logic [31:0] ewd, logic [31:0] erd);
    tbl.push_back('{wr, rd, a, be, wd, wt, rdat, ew, er, es, ee, ea, ewd, erd});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_base = 0;
    slave_auto = 1'b0; slave_mode = 0;
    tb_wait = 1'b0; tb_rdata = '0;
    sl_wait = 1'b0; sl_rdata = '0;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    tick();
    tick();
    chk1 ("rst_write", write, 1'b0);
    chk1 ("rst_read", read, 1'b0);
    chk32("rst_address", address, 32'h0);
    chk32("rst_byteenable", {28'h0, byteenable}, 32'h0);
    chk32("rst_writedata", writedata, 32'h0);
    chk32("rst_cpu_readdata", cpu_readdata, 32'h0);
    chk1 ("rst_wb_empty", wb_empty, 1'b1);
    chk1 ("rst_stall", cpu_stall, 1'b1);
    reset = 1'b0;

    // Single write, then a read held off 3 cycles, then a read+write that must act as a read.
    //   wr  rd  addr          be    wdata          wt  rdata           write read stall empty address   writedata      cpu_readdata
    add(HI, LO, 32'h100, 4'hF, 32'hDEADBEEF, LO, 32'h0,        LO, LO, LO, HI, 32'h0,   32'h0,        32'h0);
    add(LO, LO, 32'h0,   4'h0, 32'h0,        LO, 32'h0,        LO, LO, LO, LO, 32'h0,   32'h0,        32'h0);
    add(LO, LO, 32'h0,   4'h0, 32'h0,        LO, 32'h0,        HI, LO, LO, LO, 32'h100, 32'hDEADBEEF, 32'h0);
    add(LO, LO, 32'h0,   4'h0, 32'h0,        LO, 32'h0,        LO, LO, LO, HI, 32'h100, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        HI, 32'h0,        LO, LO, HI, HI, 32'h100, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        HI, 32'h0,        LO, HI, HI, HI, 32'h300, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        HI, 32'h0,        LO, HI, HI, HI, 32'h300, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        HI, 32'h0,        LO, HI, HI, HI, 32'h300, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        LO, 32'hCAFEF00D, LO, HI, HI, HI, 32'h300, 32'hDEADBEEF, 32'h0);
    add(LO, HI, 32'h300, 4'hF, 32'h0,        HI, 32'h0,        LO, LO, LO, HI, 32'h300, 32'hDEADBEEF, 32'hCAFEF00D);
    add(HI, HI, 32'h400, 4'hF, 32'h55,       LO, 32'h12345678, LO, LO, HI, HI, 32'h300, 32'hDEADBEEF, 32'hCAFEF00D);
    add(HI, HI, 32'h400, 4'hF, 32'h55,       LO, 32'h12345678, LO, HI, HI, HI, 32'h400, 32'hDEADBEEF, 32'hCAFEF00D);
    add(HI, HI, 32'h400, 4'hF, 32'h55,       LO, 32'h12345678, LO, LO, LO, HI, 32'h400, 32'hDEADBEEF, 32'h12345678);
    add(LO, LO, 32'h0,   4'h0, 32'h0,        LO, 32'h0,        LO, LO, LO, HI, 32'h400, 32'hDEADBEEF, 32'h12345678);
    add(LO, LO, 32'h0,   4'h0, 32'h0,        LO, 32'h0,        LO, LO, LO, HI, 32'h400, 32'hDEADBEEF, 32'h12345678);

    foreach (tbl[i]) begin
      cpu_write = tbl[i].wr; cpu_read = tbl[i].rd;
      cpu_address = tbl[i].a; cpu_byteenable = tbl[i].be; cpu_writedata = tbl[i].wd;
      tb_wait = tbl[i].wt; tb_rdata = tbl[i].rdat;
      #1;
      chk1 ($sformatf("tbl%0d_write", i), write, tbl[i].e_write);
      chk1 ($sformatf("tbl%0d_read", i), read, tbl[i].e_read);
      chk1 ($sformatf("tbl%0d_stall", i), cpu_stall, tbl[i].e_stall);
      chk1 ($sformatf("tbl%0d_wb_empty", i), wb_empty, tbl[i].e_empty);
      chk32($sformatf("tbl%0d_address", i), address, tbl[i].e_addr);
      chk32($sformatf("tbl%0d_writedata", i), writedata, tbl[i].e_wdat);
      chk32($sformatf("tbl%0d_cpu_readdata", i), cpu_readdata, tbl[i].e_rdata);
      tick();
    end
    idle_inputs();
    tb_wait = 1'b0;

    // Fill the buffer while the slave stalls: the fifth write must stall the core.
    slave_auto = 1'b1;
    slave_mode = 1;
    do_reset();
    for (int i = 0; i < 4; i++) cpu_wr(32'h10 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
    cpu_address = 32'h20; cpu_byteenable = 4'hF; cpu_writedata = 32'hA000_0004;
    cpu_write = 1'b1;
    #1;
    chk1 ("full_stall", cpu_stall, 1'b1);
    chk1 ("full_write_held", write, 1'b1);
    chk1 ("full_not_empty", wb_empty, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1 ("full_stall_hold", cpu_stall, 1'b1);
      chk32("full_addr_stable", address, 32'h10);
      chk32("full_wdata_stable", writedata, 32'hA000_0000);
      chk1 ("full_write_stable", write, 1'b1);
    end
    slave_mode = 0;
    cpu_wr(32'h20, 4'hF, 32'hA000_0004);
    drain_and_compare();

    // Zero-wait read: exactly two stall cycles.
    cpu_rd(32'h20, 2);

    // Write then read of the same address: the write must reach the slave first.
    cpu_wr(32'h200, 4'hF, 32'h1122_3344);
    cpu_rd(32'h200, -1);
    drain_and_compare();

    // Reset while a write is on the bus with more entries behind it.
    slave_mode = 1;
    do_reset();
    for (int i = 0; i < 3; i++) cpu_wr(32'h800 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i));
    chk1("pre_rst_write", write, 1'b1);
    reset = 1'b1;
    tick();
    chk1("midrst_write", write, 1'b0);
    chk1("midrst_read", read, 1'b0);
    chk1("midrst_wb_empty", wb_empty, 1'b1);
    reset = 1'b0;
    slave_mode = 0;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("post_rst_no_write", write, 1'b0);
    end
    chk32("post_rst_bus_writes", 32'(bus_q.size() - bus_base), 32'h0);

    // Randomized traffic with a randomly stalling slave.
    slave_mode = 2;
    do_reset();
    for (int i = 0; i < 10; i++)
      cpu_wr(32'($urandom_range(0, 15)) << 2, 4'($urandom_range(1, 15)), $urandom);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3) cpu_rd(32'($urandom_range(0, 15)) << 2, -1);
      else cpu_wr(32'($urandom_range(0, 15)) << 2, 4'($urandom_range(1, 15)), $urandom);
    end
    drain_and_compare();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_write_buffer.md
MIPS_WRITE_BUFFER -- requirements
Module: mips_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of posted-write entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: cpu_address 32 / cpu_byteenable 4 / cpu_writedata 32 / cpu_read 1 / cpu_write 1, inputs, core-side request.
REQ-005 SHALL have port: cpu_readdata  output  32  registered read result to core.
REQ-006 SHALL have port: cpu_stall  output  1  combinational; core holds its request while high.
REQ-007 SHALL have ports: address 32 / byteenable 4 / writedata 32 / read 1 / write 1, outputs, Avalon master (all registered).
REQ-008 SHALL have ports: waitrequest 1 / readdata 32, inputs, Avalon slave response.
REQ-009 SHALL have port: wb_empty  output  1  high when no write is buffered or in flight.

Function
REQ-010 SHALL hold a FIFO of DEPTH entries {address, byteenable, writedata} with count 0..DEPTH.
REQ-011 SHALL enqueue on an edge where cpu_write=1, cpu_read=0, count<DEPTH; cpu_stall=0 that cycle.
REQ-012 SHALL, when count==DEPTH and cpu_write=1, drive cpu_stall=1 and not enqueue.
REQ-013 SHALL, on simultaneous enqueue and head pop, leave count unchanged and keep FIFO order.
REQ-014 SHALL treat cpu_read=1 with cpu_write=1 as a read only; the write is discarded.
REQ-015 SHALL implement bus FSM states IDLE, WRITE, READ, RDONE.
REQ-016 IDLE: count>0 -> WRITE, loading head entry into address/byteenable/writedata, write=1 next cycle.
REQ-017 IDLE: count==0 and cpu_read=1 -> READ, loading cpu_address/cpu_byteenable, read=1 next cycle.
REQ-018 SHALL give buffered writes priority over a pending read in IDLE (read-after-write ordering).
REQ-019 WRITE: hold all master outputs stable while waitrequest=1; on waitrequest=0 pop head, write=0, -> IDLE.
REQ-020 READ: hold outputs while waitrequest=1; on waitrequest=0 register readdata into cpu_readdata, read=0, -> RDONE.
REQ-021 RDONE: cpu_stall=0 for exactly this cycle; -> IDLE next edge.
REQ-022 cpu_stall = reset | (cpu_read & state!=RDONE) | (cpu_write & !cpu_read & count==DEPTH).
REQ-023 SHALL never assert read and write together.
REQ-024 Minimum latencies: enqueue edge N -> write=1 from N+1; zero-wait read costs 2 stall cycles.
REQ-025 wb_empty = (count==0) & (state!=WRITE), registered-consistent with FIFO state.
REQ-026 Head/tail pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-027 cpu_readdata SHALL retain its value until the next completed read.

Reset
REQ-028 On reset=1 at an edge: state=IDLE, count=0, pointers=0, read=0, write=0, address=0, byteenable=0, writedata=0, cpu_readdata=0, wb_empty=1.
REQ-029 Reset mid-transaction SHALL abort it; buffered writes are dropped; read/write low the following cycle.

Verification
REQ-030 Single write 0x100/0xF/0xDEADBEEF, waitrequest=0 -> write=1 with those values one cycle after enqueue, wb_empty=1 after completion.
REQ-031 DEPTH+1 back-to-back writes, waitrequest=1 held -> cpu_stall=1 on the 5th write, count=4, bus outputs stable.
REQ-032 Write 0x200<=0x11223344 then read 0x200, slave returns 0x11223344 -> write completes before read=1; cpu_readdata=0x11223344 in RDONE.
REQ-033 Read with waitrequest=1 for 3 cycles -> read held 4 cycles, cpu_stall high until RDONE.
REQ-034 Reset asserted while write in WRITE with 2 entries buffered -> write=0, wb_empty=1 next cycle, no further bus writes.
REQ-035 10 writes with random waitrequest, slave log compared -> addresses/data in issue order, none lost (pointer wrap).
